// File: rtl/four_input_or_gate_b_sync.sv
// Cascaded four-input OR exposing partial results e=a|b, f=e|c, g=f|d.
// Optionally registered with an asynchronous active-high clear.
module four_input_or_gate_b_sync #(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g
);

  logic [WIDTH-1:0] e_n;
  logic [WIDTH-1:0] f_n;
  logic [WIDTH-1:0] g_n;

  // f is built from e and g from f so e<=f<=g holds by construction
  always_comb begin
    e_n = a | b;
    f_n = e_n | c;
    g_n = f_n | d;
  end

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] e_d, e_q;
    logic [WIDTH-1:0] f_d, f_q;
    logic [WIDTH-1:0] g_d, g_q;

    always_comb begin
      e_d = e_n;
      f_d = f_n;
      g_d = g_n;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        e_q <= '0;
        f_q <= '0;
        g_q <= '0;
      end else begin
        e_q <= e_d;
        f_q <= f_d;
        g_q <= g_d;
      end
    end

    assign e = e_q;
    assign f = f_q;
    assign g = g_q;
  end else begin : g_comb
    assign e = e_n;
    assign f = f_n;
    assign g = g_n;
  end

endmodule

// File: tb/tb_four_input_or_gate_b_sync.sv
// Directed bench for four_input_or_gate_b_sync: registered WIDTH=1,
// registered WIDTH=4 and combinational WIDTH=4 instances.
module tb_four_input_or_gate_b_sync;

  logic clk;
  logic rst;
  logic a1, b1, c1, d1;
  logic e1, f1, g1;
  logic [3:0] a4, b4, c4, d4;
  logic [3:0] e4, f4, g4;
  logic [3:0] ac, bc, cc, dc;
  logic [3:0] ec, fc, gc;
  logic rst_c;

  int vec;
  int miss;

  four_input_or_gate_b_sync #(.WIDTH(1), .REGISTERED(1)) u1 (
    .clk(clk), .rst(rst),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .e(e1), .f(f1), .g(g1)
  );

  four_input_or_gate_b_sync #(.WIDTH(4), .REGISTERED(1)) u4 (
    .clk(clk), .rst(rst),
    .a(a4), .b(b4), .c(c4), .d(d4),
    .e(e4), .f(f4), .g(g4)
  );

  four_input_or_gate_b_sync #(.WIDTH(4), .REGISTERED(0)) uc (
    .clk(clk), .rst(rst_c),
    .a(ac), .b(bc), .c(cc), .d(dc),
    .e(ec), .f(fc), .g(gc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    @(negedge clk);
    {a1, b1, c1, d1} = 4'b1111;
    rst = 1'b1;
    #1;
    vec++;
    if ({e1, f1, g1} !== 3'b000) begin
      miss++;
      $display("FAIL reset_immediate efg=%b want 000", {e1, f1, g1});
    end
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({e1, f1, g1} !== 3'b000) begin
      miss++;
      $display("FAIL reset_held efg=%b want 000", {e1, f1, g1});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vec++;
    if ({e1, f1, g1} !== 3'b111) begin
      miss++;
      $display("FAIL reset_release efg=%b want 111", {e1, f1, g1});
    end
  endtask

  task automatic test_sweep();
    logic [3:0] v;
    logic xe, xf, xg;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v = i[3:0];
      {a1, b1, c1, d1} = v;
      @(posedge clk);
      #1;
      xe = v[3] | v[2];
      xf = xe | v[1];
      xg = xf | v[0];
      vec++;
      if ({e1, f1, g1} !== {xe, xf, xg}) begin
        miss++;
        $display("FAIL sweep abcd=%b efg=%b want %b",
                 v, {e1, f1, g1}, {xe, xf, xg});
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] stim [5];
    logic [2:0] want [5];
    stim[0] = 4'b0001; want[0] = 3'b001;
    stim[1] = 4'b0010; want[1] = 3'b011;
    stim[2] = 4'b1000; want[2] = 3'b111;
    stim[3] = 4'b0100; want[3] = 3'b111;
    stim[4] = 4'b0000; want[4] = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {a1, b1, c1, d1} = stim[i];
      @(posedge clk);
      #1;
      vec++;
      if ({e1, f1, g1} !== want[i]) begin
        miss++;
        $display("FAIL single abcd=%b efg=%b want %b",
                 stim[i], {e1, f1, g1}, want[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    {a1, b1, c1, d1} = 4'b1111;
    @(posedge clk);
    #1;
    vec++;
    if ({e1, f1, g1} !== 3'b111) begin
      miss++;
      $display("FAIL mid_preload efg=%b want 111", {e1, f1, g1});
    end
    #2;
    rst = 1'b1;
    #1;
    vec++;
    if ({e1, f1, g1} !== 3'b000) begin
      miss++;
      $display("FAIL mid_clear efg=%b want 000", {e1, f1, g1});
    end
    {a1, b1, c1, d1} = 4'b0010;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec++;
    if ({e1, f1, g1} !== 3'b000) begin
      miss++;
      $display("FAIL mid_no_retain efg=%b want 000", {e1, f1, g1});
    end
    @(posedge clk);
    #1;
    vec++;
    if ({e1, f1, g1} !== 3'b011) begin
      miss++;
      $display("FAIL mid_reload efg=%b want 011", {e1, f1, g1});
    end
  endtask

  task automatic test_width4();
    logic [3:0] xe, xf, xg;
    @(negedge clk);
    a4 = 4'b0001; b4 = 4'b0010; c4 = 4'b0100; d4 = 4'b1000;
    @(posedge clk);
    #1;
    vec++;
    if ({e4, f4, g4} !== {4'b0011, 4'b0111, 4'b1111}) begin
      miss++;
      $display("FAIL w4_onehot e=%b f=%b g=%b want 0011 0111 1111",
               e4, f4, g4);
    end
    @(negedge clk);
    a4 = 4'b1010; b4 = 4'b0000; c4 = 4'b0100; d4 = 4'b0000;
    @(posedge clk);
    #1;
    vec++;
    if ({e4, f4, g4} !== {4'b1010, 4'b1110, 4'b1110}) begin
      miss++;
      $display("FAIL w4_bits e=%b f=%b g=%b want 1010 1110 1110",
               e4, f4, g4);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a4 = 4'($urandom); b4 = 4'($urandom);
      c4 = 4'($urandom); d4 = 4'($urandom);
      xe = a4 | b4;
      xf = xe | c4;
      xg = xf | d4;
      @(posedge clk);
      #1;
      vec++;
      if (((e4 & ~f4) | (f4 & ~g4)) !== 4'b0000 ||
          {e4, f4, g4} !== {xe, xf, xg}) begin
        miss++;
        $display("FAIL w4_rand e=%b f=%b g=%b want %b %b %b",
                 e4, f4, g4, xe, xf, xg);
      end
    end
  endtask

  task automatic test_comb();
    logic [3:0] xe, xf, xg;
    for (int i = 0; i < 8; i++) begin
      rst_c = i[0];
      ac = 4'($urandom); bc = 4'($urandom);
      cc = 4'($urandom); dc = 4'($urandom);
      xe = ac | bc;
      xf = xe | cc;
      xg = xf | dc;
      #1;
      vec++;
      if ({ec, fc, gc} !== {xe, xf, xg}) begin
        miss++;
        $display("FAIL comb rst=%b e=%b f=%b g=%b want %b %b %b",
                 rst_c, ec, fc, gc, xe, xf, xg);
      end
    end
    rst_c = 1'b1;
    ac = 4'b0000; bc = 4'b0000; cc = 4'b0100; dc = 4'b1001;
    #1;
    vec++;
    if ({ec, fc, gc} !== {4'b0000, 4'b0100, 4'b1101}) begin
      miss++;
      $display("FAIL comb_rst e=%b f=%b g=%b want 0000 0100 1101",
               ec, fc, gc);
    end
    rst_c = 1'b0;
  endtask

  initial begin
    vec = 0;
    miss = 0;
    rst = 1'b0;
    rst_c = 1'b0;
    {a1, b1, c1, d1} = 4'b0000;
    {a4, b4, c4, d4} = 16'h0000;
    {ac, bc, cc, dc} = 16'h0000;
    test_reset();
    test_sweep();
    test_single();
    test_mid_reset();
    test_width4();
    test_comb();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
